// File: rtl/row_scan_pkg.sv
// row_scan_pkg: shared row count, select width and FSM state type for the row scan sequencer
package row_scan_pkg;
  localparam int ROWS = 8;
  localparam int SEL_W = 3;
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} scan_state_t;
endpackage

// File: rtl/row_mask_next.sv
// row_mask_next: cyclic search for the next enabled row after cur, with wrap flag (ROW_SCAN_REVERSE_EN adds dir)
module row_mask_next
  import row_scan_pkg::*;
(
  input  logic [SEL_W-1:0] cur,
  input  logic [ROWS-1:0]  mask,
`ifdef ROW_SCAN_REVERSE_EN
  input  logic             dir,
`endif
  output logic [SEL_W-1:0] next,
  output logic             wrap,
  output logic             any
);
  logic rev;
`ifdef ROW_SCAN_REVERSE_EN
  assign rev = dir;
`else
  assign rev = 1'b0;
`endif
  assign any = |mask;
  assign wrap = rev ? next >= cur : next <= cur;
  // walk from the farthest candidate (cur itself) inward so the nearest set row wins
  always_comb begin
    next = cur;
    for (int k = ROWS; k >= 1; k--)
      if (mask[rev ? cur - SEL_W'(k) : cur + SEL_W'(k)]) next = rev ? cur - SEL_W'(k) : cur + SEL_W'(k);
  end
endmodule

// File: rtl/row_scan_sequencer.sv
// row_scan_sequencer: masked 8-row scanner with dwell/blank timing and frame pulse (ROW_SCAN_REVERSE_EN adds dir)
module row_scan_sequencer
  import row_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [ROWS-1:0]  row_mask,
`ifdef ROW_SCAN_REVERSE_EN
  input  logic             dir,
`endif
  output logic [SEL_W-1:0] row_sel,
  output logic             row_ena,
  output logic             frame_start,
  output logic             busy
);
  localparam int MAXC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic NB = BLANK_CYCLES == 0;
  localparam logic [CW-1:0] DW = CW'(DWELL_CYCLES);
  localparam logic [CW-1:0] BW = CW'(BLANK_CYCLES);
  scan_state_t state, state_n;
  logic [SEL_W-1:0] sel_n, cur, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic flag, flag_n, fs_n, load, wrap, any, rev;
`ifdef ROW_SCAN_REVERSE_EN
  assign rev = dir;
`else
  assign rev = 1'b0;
`endif
  assign cur = state == S_IDLE ? (rev ? '0 : SEL_W'(ROWS - 1)) : row_sel;
  row_mask_next u_next (
    .cur  (cur),
    .mask (row_mask),
`ifdef ROW_SCAN_REVERSE_EN
    .dir  (dir),
`endif
    .next (nxt),
    .wrap (wrap),
    .any  (any)
  );
  // next state: idle start, blank abort, end-of-phase transitions; load enters a new row period
  always_comb begin
    state_n = state;
    sel_n = row_sel;
    cnt_n = cnt - CW'(1);
    flag_n = flag;
    fs_n = 1'b0;
    load = 1'b0;
    if (state == S_IDLE) begin
      cnt_n = '0;
      if (run && any) begin
        sel_n = nxt;
        flag_n = 1'b1;
        load = 1'b1;
      end
    end else if (state == S_BLANK && !run) begin
      state_n = S_IDLE;
      cnt_n = '0;
    end else if (cnt == CW'(1)) begin
      if (state == S_BLANK) begin
        state_n = S_DRIVE;
        cnt_n = DW;
        fs_n = flag;
        flag_n = 1'b0;
      end else if (!run || !any) begin
        state_n = S_IDLE;
        cnt_n = '0;
      end else begin
        sel_n = nxt;
        flag_n = wrap;
        load = 1'b1;
      end
    end
    if (load) begin
      state_n = NB ? S_DRIVE : S_BLANK;
      cnt_n = NB ? DW : BW;
      fs_n = NB & flag_n;
      flag_n = flag_n & ~NB;
    end
  end
  // state and registered outputs, all derived from the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      row_sel <= '0;
      row_ena <= 1'b0;
      frame_start <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      flag <= 1'b0;
    end else begin
      state <= state_n;
      row_sel <= sel_n;
      row_ena <= state_n == S_DRIVE;
      frame_start <= fs_n;
      busy <= state_n != S_IDLE;
      cnt <= cnt_n;
      flag <= flag_n;
    end
  end
endmodule

// File: tb/tb_row_scan_sequencer.sv
// tb_row_scan_sequencer: randomized bench comparing two configurations against a row-period reference model
module tb_row_scan_sequencer;
  typedef struct {
    bit act;
    int row;
    int t;
    bit flag;
    bit ena;
    bit fs;
  } mdl_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic [7:0] mask = '0;
  logic [2:0] sel1, sel0;
  logic ena1, ena0, fs1, fs0, busy1, busy0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last1 = -1;
  int last0 = -1;
  bit per_en = 1'b0;
  mdl_t m1, m0;
  always #5 clk = ~clk;
  row_scan_sequencer #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .row_mask    (mask),
`ifdef ROW_SCAN_REVERSE_EN
    .dir         (1'b0),
`endif
    .row_sel     (sel1),
    .row_ena     (ena1),
    .frame_start (fs1),
    .busy        (busy1)
  );
  row_scan_sequencer #(.DWELL_CYCLES(4), .BLANK_CYCLES(0)) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .row_mask    (mask),
`ifdef ROW_SCAN_REVERSE_EN
    .dir         (1'b0),
`endif
    .row_sel     (sel0),
    .row_ena     (ena0),
    .frame_start (fs0),
    .busy        (busy0)
  );
  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask
  function automatic int lowest(logic [7:0] msk);
    for (int i = 0; i < 8; i++) if (msk[i]) return i;
    return 0;
  endfunction
  function automatic int seek(int row, logic [7:0] msk);
    for (int k = 1; k <= 8; k++) if (msk[(row + k) % 8]) return (row + k) % 8;
    return row;
  endfunction
  function automatic mdl_t mstep(mdl_t m, int b, bit rst_i, bit run_i, logic [7:0] msk);
    int p;
    int nr;
    p = b + 4;
    if (!rst_i) begin
      m = '{default: 0};
      return m;
    end
    if (!m.act) begin
      if (run_i && msk != 0) begin
        m.act = 1'b1;
        m.row = lowest(msk);
        m.t = 0;
        m.flag = 1'b1;
      end
    end else if (m.t < b && !run_i) begin
      m.act = 1'b0;
    end else if (m.t == p - 1) begin
      if (!run_i || msk == 0) m.act = 1'b0;
      else begin
        nr = seek(m.row, msk);
        m.flag = nr <= m.row;
        m.row = nr;
        m.t = 0;
      end
    end else begin
      m.t++;
    end
    m.ena = m.act && m.t >= b;
    m.fs = m.ena && m.t == b && m.flag;
    if (m.fs) m.flag = 1'b0;
    return m;
  endfunction
  task automatic tick();
    @(posedge clk);
    m1 = mstep(m1, 1, rst, run, mask);
    m0 = mstep(m0, 0, rst, run, mask);
    @(negedge clk);
    cyc++;
    check("b1_sel", int'(sel1), m1.row);
    check("b1_ena", int'(ena1), int'(m1.ena));
    check("b1_fs", int'(fs1), int'(m1.fs));
    check("b1_busy", int'(busy1), int'(m1.act));
    check("b0_sel", int'(sel0), m0.row);
    check("b0_ena", int'(ena0), int'(m0.ena));
    check("b0_fs", int'(fs0), int'(m0.fs));
    check("b0_busy", int'(busy0), int'(m0.act));
    if (per_en && fs1) begin
      if (last1 >= 0) check("b1_period", cyc - last1, $countones(mask) * 5);
      last1 = cyc;
    end
    if (per_en && fs0) begin
      if (last0 >= 0) check("b0_period", cyc - last0, $countones(mask) * 4);
      last0 = cyc;
    end
  endtask
  task automatic phase(logic [7:0] m, int n);
    per_en = 1'b0;
    run = 1'b0;
    repeat (8) tick();
    mask = m;
    run = 1'b1;
    last1 = -1;
    last0 = -1;
    per_en = 1'b1;
    repeat (n) tick();
    per_en = 1'b0;
  endtask
  initial begin
    m1 = '{default: 0};
    m0 = '{default: 0};
    mask = 8'hFF;
    repeat (2) tick();
    rst = 1'b1;
    run = 1'b1;
    per_en = 1'b1;
    repeat (100) tick();
    phase(8'b1010_0100, 60);
    phase(8'h08, 40);
    mask = 8'hFF;
    for (int i = 0; i < 100 && !(sel1 == 3'd4 && ena1); i++) tick();
    check("reach_row4", int'(sel1), 4);
    tick();
    run = 1'b0;
    repeat (6) tick();
    run = 1'b1;
    for (int i = 0; i < 20 && !(busy1 && !ena1); i++) tick();
    check("reach_blank", int'(busy1 && !ena1), 1);
    run = 1'b0;
    repeat (3) tick();
    run = 1'b1;
    for (int i = 0; i < 100 && !(sel1 == 3'd6 && ena1); i++) tick();
    check("reach_row6", int'(sel1), 6);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 20 && !ena1; i++) tick();
    check("reach_drive", int'(ena1), 1);
    mask = 8'h00;
    repeat (10) tick();
    mask = 8'h30;
    repeat (20) tick();
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 99) != 0;
      run = $urandom_range(0, 19) != 0;
      if ($urandom_range(0, 15) == 0) mask = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
